// File: rtl/rr_arb_in_queue.sv
// rr_arb_in_queue: bank of independent per-requester circular FIFOs feeding
// a round-robin arbiter. Each FIFO buffers one ready/valid stream, presents
// its head entry on dout and its non-empty flag on req, and is popped by the
// matching grant bit (grant may be multi-hot).
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            synchronous active-high reset
//   in_valid[i]    push request for FIFO i
//   in_data[i]     push payload for FIFO i
//   in_ready[i]    FIFO i can accept (not full, not in reset)
//   req[i]         FIFO i non-empty
//   dout[i]        head entry of FIFO i
//   grant[i]       pop FIFO i this cycle
//   err_pop_empty  sticky flag: grant seen for an empty FIFO
//   level[i]       occupancy of FIFO i (only with RR_ARB_IN_QUEUE_LEVEL_EN)
//
// Optional feature macro: RR_ARB_IN_QUEUE_LEVEL_EN adds the level output.

module rr_arb_in_queue #(
    parameter int unsigned NUM_INPUTS    = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned IN_FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] in_valid,
    input  logic [DATA_WIDTH-1:0] in_data [NUM_INPUTS-1:0],
    output logic [NUM_INPUTS-1:0] in_ready,
    output logic [NUM_INPUTS-1:0] req,
    output logic [DATA_WIDTH-1:0] dout [NUM_INPUTS-1:0],
    input  logic [NUM_INPUTS-1:0] grant,
    output logic                  err_pop_empty
`ifdef RR_ARB_IN_QUEUE_LEVEL_EN
    ,
    output logic [$clog2(IN_FIFO_DEPTH):0] level [NUM_INPUTS-1:0]
`endif
);

    localparam int unsigned PTR_W = $clog2(IN_FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(IN_FIFO_DEPTH) + 1;

    logic [PTR_W-1:0]      wr_ptr [NUM_INPUTS-1:0];
    logic [PTR_W-1:0]      rd_ptr [NUM_INPUTS-1:0];
    logic [CNT_W-1:0]      count  [NUM_INPUTS-1:0];
    logic [DATA_WIDTH-1:0] mem    [NUM_INPUTS-1:0][IN_FIFO_DEPTH-1:0];

    logic [NUM_INPUTS-1:0] push_c;
    logic [NUM_INPUTS-1:0] pop_c;
    logic [NUM_INPUTS-1:0] bad_grant_c;

    // Handshake decode; ready depends only on stored count, never on grant.
    always_comb begin
        in_ready    = '0;
        req         = '0;
        push_c      = '0;
        pop_c       = '0;
        bad_grant_c = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            in_ready[i]    = (count[i] != CNT_W'(IN_FIFO_DEPTH)) && !rst;
            req[i]         = (count[i] != '0);
            push_c[i]      = in_valid[i] & in_ready[i];
            pop_c[i]       = grant[i] & req[i];
            bad_grant_c[i] = grant[i] & ~req[i];
        end
    end

    // Head-of-queue read, combinational from the storage array.
    always_comb begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            dout[i] = mem[i][rd_ptr[i]];
        end
    end

    // Pointer and occupancy state; full/empty are tracked by count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                if (push_c[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop_c[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                if (push_c[i] && !pop_c[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (pop_c[i] && !push_c[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (push_c[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i];
            end
        end
    end

    // Sticky error for a grant aimed at an empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pop_empty <= 1'b0;
        end else if (|bad_grant_c) begin
            err_pop_empty <= 1'b1;
        end
    end

`ifdef RR_ARB_IN_QUEUE_LEVEL_EN
    // Occupancy export straight from the count registers.
    always_comb begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            level[i] = count[i];
        end
    end
`else
    // Occupancy stays internal when the level port is not built.
`endif

endmodule

// File: doc/rr_arb_in_queue.md
Name: rr_arb_in_queue

Overview:
- Per-requester input queue bank that sits directly upstream of the round-robin arbiter.
- Buffers one ready/valid stream per input in an independent circular FIFO.
- Drives the arbiter's req vector (FIFO non-empty) and data vector (FIFO heads).
- Pops each FIFO when the arbiter returns a grant for that input.

Parameters:
- NUM_INPUTS, 4: number of requesters / FIFOs.
- DATA_WIDTH, 8: payload width per entry.
- IN_FIFO_DEPTH, 8: entries per FIFO; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NUM_INPUTS  per-input push request.
- in_data  input  DATA_WIDTH x NUM_INPUTS (unpacked [NUM_INPUTS-1:0])  per-input push payload.
- in_ready  output  NUM_INPUTS  per-input FIFO can accept.
- req  output  NUM_INPUTS  FIFO i non-empty; feeds arbiter req.
- dout  output  DATA_WIDTH x NUM_INPUTS (unpacked)  head entry of FIFO i; feeds arbiter in[].
- grant  input  NUM_INPUTS  arbiter grant; bit i pops FIFO i this cycle. May be multi-hot (multi-output arbiter).
- err_pop_empty  output  1  sticky: a grant arrived for an empty FIFO.

Behaviour:
- Reset (rst=1 at posedge): all read/write pointers and counts = 0; req=0; in_ready=0 while rst is high; err_pop_empty=0; dout contents don't-care (bench must not check). Reset mid-operation discards all queued entries, with no partial pops.
- After reset deasserts: in_ready = all ones from the first cycle with rst=0.
- Per FIFO i, all FIFOs independent:
  - count_i width = $clog2(IN_FIFO_DEPTH)+1.
  - in_ready[i] = (count_i != IN_FIFO_DEPTH) && !rst. No combinational path from grant to in_ready; a full FIFO refuses a push even when popped in the same cycle.
  - push_i = in_valid[i] & in_ready[i] → mem[wr_ptr] <= in_data[i]; wr_ptr++ (wraps modulo depth).
  - pop_i = grant[i] & req[i] → rd_ptr++ (wraps).
  - push and pop in the same cycle: both occur, count unchanged. On an empty FIFO, push only (pop_i=0 since req=0). No same-cycle passthrough.
  - count: +1 on push only, -1 on pop only.
  - req[i] = (count_i != 0), registered state. Latency: an entry pushed at edge N is visible on req/dout after edge N (usable the cycle after acceptance).
  - dout[i] = mem[rd_ptr_i], combinational read of the register array. Stable while req[i]=1 and no pop.
- grant[i] with req[i]=0: ignored (no pointer change); sets err_pop_empty=1 until reset.
- Ordering: strict FIFO per input; no ordering across inputs.
- Pointers wrap at IN_FIFO_DEPTH-1 → 0; full/empty distinguished by count, not pointer equality.

Optional Feature:
- Macro: RR_ARB_IN_QUEUE_LEVEL_EN.
- Defined: adds output port level, $clog2(IN_FIFO_DEPTH)+1 bits x NUM_INPUTS (unpacked). level[i] = count_i, registered; 0 at reset. Intended for occupancy-weighted arbitration and debug.
- Undefined: port absent; count logic unchanged internally. No other behaviour differs.

Test Plan:
- Reset then idle → in_ready=4'b1111, req=4'b0000, err_pop_empty=0; assert rst for 1 cycle mid-traffic (FIFO0 holding 3 entries) → req=0 next cycle, count 0.
- Push 0x11,0x22,0x33 into input 2, grant=0 → req=4'b0100 one cycle after first push, dout[2]=0x11; grant[2] for 3 cycles → dout 0x22, 0x33, then req[2]=0.
- Fill input 0 with 8 entries (0x00..0x07) → in_ready[0]=0 after 8th; 9th push with grant[0]=1 same cycle → refused, one pop occurs, in_ready[0]=1 next cycle; drain order 0x00..0x07.
- Input 1 holds 1 entry; push 0xAA and grant[1] same cycle → count stays 1, dout[1]=0xAA next cycle; keep simultaneous push/pop for 20 cycles → pointer wrap, data order preserved.
- grant=4'b1000 with FIFO3 empty → err_pop_empty=1 next cycle and stays 1; other FIFOs unaffected.
- Random valid on all 4 inputs with multi-hot grant (only where req set), 10k cycles → scoreboard per-input order, no loss or duplication; with RR_ARB_IN_QUEUE_LEVEL_EN, level[i] matches model count every cycle.
